biquad_coeff_sequencer: RTL
===========================

Name: biquad_coeff_sequencer

Overview:
- Coefficient loader/scheduler for a bank of 8-sample incremental biquad pipelines.
- Host writes coefficient sets into a shadow RAM, one set per biquad target, then commits a target.
- Block drives that target's coeff write strobes in reverse order, holding data per the target's internal registered write enable.
- Issues coeff_update either immediately or aligned to a frame sync, so every DSP B2 register switches on the same clock.

Parameters:
- NCOEFF, 2, coefficient words per set; issued highest index first.
- NTARGET, 2, number of biquad instances served; one-hot strobes.
- SYNC_UPDATE, 1, 1 = update waits for update_sync_i; 0 = update issued immediately after the last write.
- CBITS, 18, coefficient word width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- host_adr_i  in  clog2(NCOEFF)  coefficient index for a shadow write.
- host_tgt_i  in  clog2(NTARGET)  target for a shadow write or commit.
- host_dat_i  in  CBITS  shadow write data.
- host_wr_i  in  1  shadow write strobe.
- host_commit_i  in  1  commit request for host_tgt_i.
- update_sync_i  in  1  frame-aligned update strobe.
- coeff_dat_o  out  CBITS  coefficient bus, shared by all targets.
- coeff_wr_o  out  NTARGET  per-target write strobe.
- coeff_update_o  out  NTARGET  per-target update strobe.
- busy_o  out  1  sequence in progress.
- done_o  out  1  one-cycle pulse when a sequence completes.
- err_o  out  1  one-cycle pulse on a rejected commit or shadow write.

Behaviour:
- Reset (async, any state, mid-sequence included):
  - State IDLE; all outputs 0.
  - Any partially written target simply stays un-updated; its B2 is untouched.
  - Shadow RAM is not reset; contents are retained.
- Shadow RAM: NTARGET*NCOEFF words of CBITS, address {tgt,adr}, synchronous write, 1-cycle registered read.
- States: IDLE -> LOAD -> (WAIT_SYNC) -> UPDATE -> DONE -> IDLE.
- IDLE:
  - host_commit_i high in cycle 0 latches the target T and sets busy_o from cycle 1.
  - Go to LOAD with index k = NCOEFF-1.
- LOAD:
  - Write j (j = 0..NCOEFF-1, coefficient index NCOEFF-1-j) asserts coeff_wr_o[T] in cycle 2+2j.
  - coeff_dat_o = shadow[T][NCOEFF-1-j], stable in cycles 2+2j and 3+2j, because the target captures data one clock after the strobe.
  - coeff_wr_o is low on odd cycles, so strobes never occur back to back.
- After the last write, the next state is entered at cycle 2*NCOEFF+2:
  - SYNC_UPDATE=0: UPDATE; coeff_update_o[T] high for exactly cycle 2*NCOEFF+2.
  - SYNC_UPDATE=1: WAIT_SYNC. The first update_sync_i sampled high in cycle s >= 2*NCOEFF+2 gives coeff_update_o[T] high in cycle s+1. Sync pulses during IDLE or LOAD are ignored.
- DONE: done_o high for one cycle, the cycle after the update pulse. busy_o falls in that same cycle. IDLE follows.
- coeff_dat_o holds its last value while idle.
- Only target T's strobes ever assert; all other bits stay 0.
- Boundary cases:
  - host_commit_i while busy_o=1: dropped, err_o pulses the next cycle. No queueing.
  - Commit and DONE in the same cycle: commit is rejected.
  - host_wr_i to target T while busy_o=1: write blocked, err_o pulses.
  - host_wr_i to other targets is always accepted.
  - host_wr_i and host_commit_i in the same IDLE cycle to the same target: write is accepted first, and the committed set includes it (write-first RAM).
  - Simultaneous err sources produce a single err_o pulse.
  - host_tgt_i >= NTARGET or host_adr_i >= NCOEFF: ignored, err_o pulses.

Test Plan:
- NCOEFF=2, SYNC_UPDATE=0. Write tgt0 = {adr0:0x00111, adr1:0x3FFFF}; commit in cycle 0.
  -> coeff_wr_o=01 in cycles 2 and 4 only.
  -> coeff_dat_o=0x3FFFF in cycles 2-3, 0x00111 in cycles 4-5.
  -> coeff_update_o=01 in cycle 6; done_o in cycle 7; busy_o high cycles 1-6.
- SYNC_UPDATE=1: commit tgt1, pulse update_sync_i in cycle 3 and cycle 20.
  -> cycle-3 pulse ignored; coeff_update_o=10 in cycle 21 only; done_o in cycle 22.
- Commit tgt0 in cycle 0 and again in cycle 3; host_wr_i to tgt0 in cycle 4.
  -> err_o in cycles 4 and 5; shadow tgt0 unchanged (readback on next commit shows the original words); one sequence only.
- Assert rst in cycle 3 of a sequence.
  -> all outputs 0 immediately, state IDLE.
  -> a new commit in cycle 10 runs a full sequence with correct data.
- Same-cycle host_wr_i (tgt0, adr1, 0x12345) and commit tgt0.
  -> first coeff_dat_o = 0x12345.
- Commit tgt1 while host writes tgt0 continuously.
  -> no err_o; tgt0 shadow updated; coeff_wr_o[0] never asserts.

Source files
------------

// File: rtl/biquad_coeff_sequencer_if.sv
// Host-side shadow-write/commit bus and coefficient distribution bus of the
// biquad coefficient sequencer, with master (host/bench) and slave (sequencer) views.
interface biquad_coeff_sequencer_if #(
  parameter int NCOEFF  = 2,
  parameter int NTARGET = 2,
  parameter int CBITS   = 18
);
  localparam int AW = (NCOEFF  > 1) ? $clog2(NCOEFF)  : 1;
  localparam int TW = (NTARGET > 1) ? $clog2(NTARGET) : 1;

  logic [AW-1:0]      host_adr_i;
  logic [TW-1:0]      host_tgt_i;
  logic [CBITS-1:0]   host_dat_i;
  logic               host_wr_i;
  logic               host_commit_i;
  logic               update_sync_i;
  logic [CBITS-1:0]   coeff_dat_o;
  logic [NTARGET-1:0] coeff_wr_o;
  logic [NTARGET-1:0] coeff_update_o;
  logic               busy_o;
  logic               done_o;
  logic               err_o;

  modport master (
    output host_adr_i, host_tgt_i, host_dat_i, host_wr_i, host_commit_i, update_sync_i,
    input  coeff_dat_o, coeff_wr_o, coeff_update_o, busy_o, done_o, err_o
  );

  modport slave (
    input  host_adr_i, host_tgt_i, host_dat_i, host_wr_i, host_commit_i, update_sync_i,
    output coeff_dat_o, coeff_wr_o, coeff_update_o, busy_o, done_o, err_o
  );
endinterface

// File: rtl/biquad_coeff_sequencer.sv
// Shadow coefficient RAM plus sequencer that replays a committed set into one
// biquad target (highest index first) and then fires its coeff_update strobe.
module biquad_coeff_sequencer #(
  parameter int NCOEFF      = 2,
  parameter int NTARGET     = 2,
  parameter int SYNC_UPDATE = 1,
  parameter int CBITS       = 18
) (
  input  logic                     clk,
  input  logic                     rst,
  biquad_coeff_sequencer_if.slave  bus
);
  localparam int AW    = (NCOEFF  > 1) ? $clog2(NCOEFF)  : 1;
  localparam int TW    = (NTARGET > 1) ? $clog2(NTARGET) : 1;
  localparam int DEPTH = 2 ** (AW + TW);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT_SYNC, S_UPDATE, S_DONE} state_t;

  state_t             state_q;
  logic [TW-1:0]      tgt_q;
  logic [AW-1:0]      k_q;
  logic               phase_q;
  logic               last_q;
  logic [CBITS-1:0]   dat_q;
  logic [NTARGET-1:0] wr_q;
  logic [NTARGET-1:0] upd_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;

  logic [CBITS-1:0]   shadow_mem [DEPTH];

  logic               tgt_bad_d;
  logic               adr_bad_d;
  logic               wr_ok_d;
  logic               commit_ok_d;
  logic               err_d;
  logic [NTARGET-1:0] tgt_hot_d;

  always_comb begin
    tgt_bad_d   = 32'(bus.host_tgt_i) >= NTARGET;
    adr_bad_d   = 32'(bus.host_adr_i) >= NCOEFF;
    // The set being replayed is frozen; other targets' sets stay writable.
    wr_ok_d     = bus.host_wr_i && !tgt_bad_d && !adr_bad_d &&
                  !(busy_q && (bus.host_tgt_i == tgt_q));
    commit_ok_d = bus.host_commit_i && !tgt_bad_d && (state_q == S_IDLE);
    err_d       = (bus.host_wr_i && !wr_ok_d) || (bus.host_commit_i && !commit_ok_d);
    tgt_hot_d          = '0;
    tgt_hot_d[tgt_q]   = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_ok_d) begin
      shadow_mem[{bus.host_tgt_i, bus.host_adr_i}] <= bus.host_dat_i;
    end
  end

  // LOAD alternates a read/strobe phase with a hold phase, so each word sits on
  // the bus for the strobe cycle and the following capture cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      tgt_q   <= '0;
      k_q     <= '0;
      phase_q <= 1'b0;
      last_q  <= 1'b0;
      dat_q   <= '0;
      wr_q    <= '0;
      upd_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q  <= err_d;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (commit_ok_d) begin
            tgt_q   <= bus.host_tgt_i;
            k_q     <= AW'(NCOEFF - 1);
            phase_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (!phase_q) begin
            if (last_q) begin
              if (SYNC_UPDATE != 0) begin
                state_q <= S_WAIT_SYNC;
              end else begin
                upd_q   <= tgt_hot_d;
                state_q <= S_UPDATE;
              end
            end else begin
              dat_q   <= shadow_mem[{tgt_q, k_q}];
              wr_q    <= tgt_hot_d;
              phase_q <= 1'b1;
            end
          end else begin
            wr_q    <= '0;
            phase_q <= 1'b0;
            if (k_q == '0) begin
              last_q <= 1'b1;
            end else begin
              k_q <= k_q - 1'b1;
            end
          end
        end
        S_WAIT_SYNC: begin
          if (bus.update_sync_i) begin
            upd_q   <= tgt_hot_d;
            state_q <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          upd_q   <= '0;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_DONE;
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.coeff_dat_o    = dat_q;
  assign bus.coeff_wr_o     = wr_q;
  assign bus.coeff_update_o = upd_q;
  assign bus.busy_o         = busy_q;
  assign bus.done_o         = done_q;
  assign bus.err_o          = err_q;
endmodule
